// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register bank with async read ports, sync write port, bypass and busy scoreboard
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   we, wa, wd            write port (one write per cycle)
//   ra, rd                NREAD packed read address / read data ports (combinational)
//   mark_en, mark_addr    flag a register as having a pending producer
//   busy                  per read port: addressed register still has a pending result
//   busy_vec              registered scoreboard, one bit per register
module reg_file_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [WIDTH-1:0]       wd,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    input  logic                   mark_en,
    input  logic [AW-1:0]          mark_addr,
    output logic [NREAD-1:0]       busy,
    output logic [DEPTH-1:0]       busy_vec
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] sb;
    logic [DEPTH-1:0] sb_nxt;
    logic             wr_ok;
    logic             mk_ok;

    // An address names real, writable/markable storage: in range and not the hardwired zero register.
    function automatic logic usable(input logic [AW-1:0] a);
        return (32'(a) < 32'(DEPTH)) && !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    assign wr_ok = we && usable(wa);
    assign mk_ok = mark_en && usable(mark_addr);

    // Mark is applied after the write clear so a new producer issued in the same
    // cycle as the old result supersedes it.
    always_comb begin
        sb_nxt = sb;
        if (wr_ok) begin
            sb_nxt[wa] = 1'b0;
        end
        if (mk_ok) begin
            sb_nxt[mark_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            sb_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < DEPTH; n++) begin
                mem[n] <= '0;
            end
            sb <= '0;
        end else begin
            if (wr_ok) begin
                mem[wa] <= wd;
            end
            sb <= sb_nxt;
        end
    end

    assign busy_vec = sb;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    a;
        logic             hit;
        logic [WIDTH-1:0] d;
        logic             b;

        assign a = ra[i*AW +: AW];
        // Only a non-dropped write can hit, so register 0 is never forwarded when hardwired.
        assign hit = BYPASS && wr_ok && (wa == a);

        always_comb begin
            d = '0;
            b = 1'b0;
            if (in_range(a) && !(ZERO_REG && (a == '0))) begin
                d = mem[a];
                b = sb[a];
            end
            if (hit) begin
                d = wd;
                b = 1'b0;
            end
        end

        assign rd[i*WIDTH +: WIDTH] = d;
        assign busy[i]              = b;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb (default, no-bypass and 64x16x3 builds)
module tb_reg_file_sb;

    logic         clk;
    logic         reset;

    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [9:0]   ra;
    logic         mark_en;
    logic [4:0]   mark_addr;
    logic [63:0]  rd_m;
    logic [1:0]   busy_m;
    logic [31:0]  bv_m;
    logic [63:0]  rd_nb;
    logic [1:0]   busy_nb;
    logic [31:0]  bv_nb;

    logic         w_we;
    logic [3:0]   w_wa;
    logic [63:0]  w_wd;
    logic [11:0]  w_ra;
    logic [191:0] w_rd;
    logic         w_mark_en;
    logic [3:0]   w_mark_addr;
    logic [2:0]   w_busy;
    logic [15:0]  w_bv;

    int n_checks;
    int n_fail;

    string       tq[$];
    int          sq[$];
    int          pq[$];
    logic [63:0] eq[$];

    logic [63:0] wm [16];
    logic [15:0] wsb;

    reg_file_sb u_main (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_m),
        .mark_en(mark_en), .mark_addr(mark_addr), .busy(busy_m), .busy_vec(bv_m)
    );

    reg_file_sb #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nb),
        .mark_en(mark_en), .mark_addr(mark_addr), .busy(busy_nb), .busy_vec(bv_nb)
    );

    reg_file_sb #(.WIDTH(64), .DEPTH(16), .NREAD(3)) u_wide (
        .clk(clk), .reset(reset), .we(w_we), .wa(w_wa), .wd(w_wd), .ra(w_ra), .rd(w_rd),
        .mark_en(w_mark_en), .mark_addr(w_mark_addr), .busy(w_busy), .busy_vec(w_bv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel, input int p);
        case (sel)
            0: return 64'(rd_m[p*32 +: 32]);
            1: return 64'(busy_m);
            2: return 64'(bv_m);
            3: return 64'(rd_nb[p*32 +: 32]);
            4: return 64'(busy_nb);
            5: return w_rd[p*64 +: 64];
            6: return 64'(w_busy);
            7: return 64'(w_bv);
            8: return 64'(bv_nb);
            default: return '0;
        endcase
    endfunction

    task automatic push(input string t, input int s, input int p, input logic [63:0] e);
        tq.push_back(t);
        sq.push_back(s);
        pq.push_back(p);
        eq.push_back(e);
    endtask

    task automatic drain();
        string       t;
        int          s;
        int          p;
        logic [63:0] e;
        while (tq.size() > 0) begin
            t = tq.pop_front();
            s = sq.pop_front();
            p = pq.pop_front();
            e = eq.pop_front();
            check(t, observe(s, p), e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check();
        #3;
        drain();
    endtask

    task automatic check_all_zero(input string t);
        for (int r = 0; r < 32; r++) begin
            ra = {5'(r), 5'(r)};
            #1;
            push({t, "_rd0"}, 0, 0, 64'h0);
            push({t, "_rd1"}, 0, 1, 64'h0);
            push({t, "_busy"}, 1, 0, 64'h0);
            push({t, "_nb_rd0"}, 3, 0, 64'h0);
            drain();
        end
    endtask

    initial begin
        logic        wr_ok;
        logic [3:0]  a;
        logic [63:0] e;
        logic [2:0]  be;

        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        we = 1'b1; wa = 5'd5; wd = 32'h1; ra = '0; mark_en = 1'b1; mark_addr = 5'd6;
        w_we = 1'b0; w_wa = '0; w_wd = '0; w_ra = '0; w_mark_en = 1'b0; w_mark_addr = '0;
        for (int n = 0; n < 16; n++) wm[n] = '0;
        wsb = '0;

        // writes and marks during reset must not land
        step();
        step();
        we = 1'b0; mark_en = 1'b0;
        push("rst_bv", 2, 0, 64'h0);
        push("rst_nb_bv", 8, 0, 64'h0);
        push("rst_w_bv", 7, 0, 64'h0);
        push("rst_w_busy", 6, 0, 64'h0);
        drain();
        check_all_zero("rst");
        step();
        reset = 1'b1;

        // write then read on both ports; register 0 is hardwired
        step();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step();
        we = 1'b0; ra = {5'd5, 5'd5};
        push("wr5_rd0", 0, 0, 64'hDEADBEEF);
        push("wr5_rd1", 0, 1, 64'hDEADBEEF);
        push("wr5_nb_rd0", 3, 0, 64'hDEADBEEF);
        settle_check();
        step();
        we = 1'b1; wa = 5'd0; wd = 32'h1234; ra = {5'd0, 5'd0};
        push("bypass_r0", 0, 0, 64'h0);
        settle_check();
        step();
        we = 1'b0;
        push("zero_rd0", 0, 0, 64'h0);
        push("zero_nb_rd0", 3, 1, 64'h0);
        settle_check();

        // same-cycle bypass vs. no-bypass build
        step();
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = {5'd5, 5'd7};
        push("byp_rd0", 0, 0, 64'hA5A5A5A5);
        push("byp_nb_old", 3, 0, 64'h0);
        push("byp_rd1_other", 0, 1, 64'hDEADBEEF);
        settle_check();
        step();
        we = 1'b0;
        push("byp_nb_new", 3, 0, 64'hA5A5A5A5);
        push("byp_rd0_hold", 0, 0, 64'hA5A5A5A5);
        settle_check();

        // mark then release by write
        mark_en = 1'b1; mark_addr = 5'd9;
        step();
        mark_en = 1'b0; ra = {5'd9, 5'd7};
        push("mark9_busy", 1, 0, 64'h2);
        push("mark9_bv", 2, 0, 64'h200);
        push("mark9_nb_busy", 4, 0, 64'h2);
        settle_check();
        step();
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        push("rel9_busy", 1, 0, 64'h0);
        push("rel9_bv_still", 2, 0, 64'h200);
        push("rel9_nb_busy", 4, 0, 64'h2);
        push("rel9_rd1", 0, 1, 64'h99);
        settle_check();
        step();
        we = 1'b0;
        push("rel9_bv_clr", 2, 0, 64'h0);
        push("rel9_nb_clr", 4, 0, 64'h0);
        push("rel9_nb_bv", 8, 0, 64'h0);
        settle_check();

        // mark and write on same register: mark wins, data still written
        step();
        mark_en = 1'b1; mark_addr = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h33;
        step();
        mark_en = 1'b0; we = 1'b0; ra = {5'd0, 5'd3};
        push("mw3_rd0", 0, 0, 64'h33);
        push("mw3_bv", 2, 0, 64'h8);
        push("mw3_busy", 1, 0, 64'h1);
        push("mw3_rd1_r0", 0, 1, 64'h0);
        settle_check();
        step();
        mark_en = 1'b1; mark_addr = 5'd0;
        step();
        mark_en = 1'b0;
        push("mark0_bv", 2, 0, 64'h8);
        push("mark0_busy", 1, 0, 64'h1);
        settle_check();

        // marks 1..4, then reset in the middle of a write/mark cycle
        step();
        for (int k = 1; k <= 4; k++) begin
            mark_en = 1'b1; mark_addr = 5'(k);
            step();
        end
        mark_en = 1'b1; mark_addr = 5'd5; we = 1'b1; wa = 5'd2; wd = 32'h22;
        push("mark14_bv", 2, 0, 64'h1E);
        drain();
        #2;
        reset = 1'b0;
        #1;
        we = 1'b0; mark_en = 1'b0;
        push("midrst_bv", 2, 0, 64'h0);
        push("midrst_nb_bv", 8, 0, 64'h0);
        drain();
        check_all_zero("midrst");
        step();
        reset = 1'b1;
        step();
        we = 1'b1; wa = 5'd2; wd = 32'h77;
        step();
        we = 1'b0; ra = {5'd2, 5'd2};
        push("post_rst_rd0", 0, 0, 64'h77);
        push("post_rst_bv", 2, 0, 64'h0);
        settle_check();

        // 64x16x3 build: random traffic against a reference model
        step();
        for (int it = 0; it < 120; it++) begin
            w_we        = 1'($urandom_range(0, 1));
            w_wa        = 4'($urandom_range(0, 15));
            w_wd        = {$urandom, $urandom};
            w_mark_en   = ($urandom_range(0, 2) == 0);
            w_mark_addr = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(0, 3) == 0) w_ra[p*4 +: 4] = w_wa;
                else w_ra[p*4 +: 4] = 4'($urandom_range(0, 15));
            end
            wr_ok = w_we && (w_wa != 4'd0);
            be = '0;
            for (int p = 0; p < 3; p++) begin
                a = w_ra[p*4 +: 4];
                e = (a == 4'd0) ? 64'h0 : wm[a];
                be[p] = (a != 4'd0) && wsb[a];
                if (wr_ok && (w_wa == a)) begin
                    e = w_wd;
                    be[p] = 1'b0;
                end
                push($sformatf("wide_rd%0d_it%0d", p, it), 5, p, e);
            end
            push($sformatf("wide_busy_it%0d", it), 6, 0, 64'(be));
            push($sformatf("wide_bv_it%0d", it), 7, 0, 64'(wsb));
            settle_check();
            if (wr_ok) begin
                wm[w_wa]  = w_wd;
                wsb[w_wa] = 1'b0;
            end
            if (w_mark_en && (w_mark_addr != 4'd0)) wsb[w_mark_addr] = 1'b1;
            step();
        end
        w_we = 1'b0; w_mark_en = 1'b0;
        push("wide_bv_final", 7, 0, 64'(wsb));
        drain();

        check("sb_empty", 64'(tq.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
